// File: rtl/clk_tick_gen_if.sv
// Divisor write port for clk_tick_gen: valid/ready request plus
// the registered out-of-range error pulse returned by the generator.
interface clk_tick_gen_if #(
   parameter int CNT_W = 26
);
   logic             wr_valid;
   logic             wr_ready;
   logic [2:0]       wr_ch;
   logic [CNT_W-1:0] wr_div;
   logic             wr_err;

   modport master (
      output wr_valid, wr_ch, wr_div,
      input  wr_ready, wr_err
   );

   modport slave (
      input  wr_valid, wr_ch, wr_div,
      output wr_ready, wr_err
   );
endinterface

// File: rtl/clk_tick_gen.sv
// Multi-channel 50% duty clock and tick generator with shadowed,
// runtime-programmable half-period. Optional macro: PHASE_SYNC_EN.
module clk_tick_gen #(
   parameter int                      NUM_CH   = 2,
   parameter int                      CNT_W    = 26,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'd100000, 26'd25000000}
) (
   input  logic              clk_50Mhz,
   input  logic              rst,
`ifdef PHASE_SYNC_EN
   input  logic              sync_in,
`endif
   input  logic [NUM_CH-1:0] ch_en,
   clk_tick_gen_if.slave     wr,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pend
);

   logic [CNT_W-1:0] cnt    [NUM_CH];
   logic [CNT_W-1:0] hp     [NUM_CH];
   logic [CNT_W-1:0] shadow [NUM_CH];
   logic [7:0]       pend_x;
   logic             in_range;
   logic             accept;

   // A zero half-period would never reach terminal count; treat it as 1.
   function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   // Widen pend to the full 3-bit channel address space.
   always_comb begin
      pend_x = '0;
      pend_x[NUM_CH-1:0] = pend;
   end

   assign in_range    = int'(wr.wr_ch) < NUM_CH;
   assign wr.wr_ready = in_range ? ~pend_x[wr.wr_ch] : 1'b1;
   assign accept      = wr.wr_valid & wr.wr_ready;

   // Per-channel counters, divided clocks, ticks and shadow divisors.
   always_ff @(posedge clk_50Mhz or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]    <= '0;
            hp[i]     <= nz(DIV_INIT[i*CNT_W +: CNT_W]);
            shadow[i] <= '0;
         end
         clk_out   <= '0;
         tick      <= '0;
         pend      <= '0;
         wr.wr_err <= 1'b0;
      end else begin
         wr.wr_err <= accept & ~in_range;
         for (int i = 0; i < NUM_CH; i++) begin
            tick[i] <= 1'b0;
`ifdef PHASE_SYNC_EN
            if (sync_in) begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               if (pend[i]) begin
                  hp[i]   <= shadow[i];
                  pend[i] <= 1'b0;
               end
            end else
`endif
            if (ch_en[i]) begin
               if (cnt[i] == hp[i] - CNT_W'(1)) begin
                  cnt[i]     <= '0;
                  clk_out[i] <= ~clk_out[i];
                  tick[i]    <= ~clk_out[i];
                  if (pend[i]) begin
                     hp[i]   <= shadow[i];
                     pend[i] <= 1'b0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else if (pend[i]) begin
               hp[i]   <= shadow[i];
               pend[i] <= 1'b0;
               cnt[i]  <= '0;
            end
            // Accept only happens with pend clear, so it never races the apply.
            if (accept && in_range && int'(wr.wr_ch) == i) begin
               shadow[i] <= nz(wr.wr_div);
               pend[i]   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
Parametrised multi-channel clock/tick generator driven from the 50 MHz board clock; successor to the fixed two-output divider.
- Each channel produces a 50%-duty divided clock plus a single-cycle tick strobe.
- Half-period divisor is runtime-programmable through a valid/ready write port.
- Per-channel enable.
- Feeds the clock counter (1 Hz) and display multiplexer (scan rate) blocks.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
CNT_W, 26, counter and divisor width in bits
DIV_INIT, {26'd100000, 26'd25000000}, flattened reset half-period per channel, channel 0 in LSBs; defaults give 1 Hz on ch0 and 250 Hz on ch1

Ports:
clk_50Mhz  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
ch_en  in  NUM_CH  per-channel run enable
wr_valid  in  1  divisor write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_ch  in  3  target channel index
wr_div  in  CNT_W  new half-period in clk_50Mhz cycles
wr_err  out  1  one-cycle pulse: accepted write had wr_ch >= NUM_CH
clk_out  out  NUM_CH  divided clocks, 50% duty
tick  out  NUM_CH  one-cycle strobe per output period
pend  out  NUM_CH  shadow divisor waiting to be applied

Behaviour:
- Reset (async, rst=1): counters=0; hp[i]=DIV_INIT slice i, with 0 coerced to 1; clk_out=0, tick=0, pend=0, wr_err=0. All outputs registered.
- Channel running (ch_en[i]=1):
  - cnt[i] increments each cycle.
  - Terminal count when cnt[i]==hp[i]-1: cnt[i]<=0 and clk_out[i] toggles.
  - Output period = 2*hp[i] cycles, high and low phases each hp[i] cycles.
  - tick[i]=1 for exactly the one cycle in which clk_out[i] is first high after a 0->1 toggle; otherwise 0.
- ch_en[i]=0: cnt[i] and clk_out[i] frozen, tick[i]=0. On re-enable, counting resumes from the frozen count; no extra toggle.
- Write port:
  - wr_ready = ~pend[wr_ch] for wr_ch < NUM_CH; wr_ready = 1 for an out-of-range wr_ch.
  - On accept: shadow[wr_ch] <= (wr_div==0 ? 1 : wr_div) and pend[wr_ch] <= 1.
  - Out-of-range wr_ch: write dropped, wr_err pulses 1 cycle in the following cycle.
- Divisor apply:
  - At terminal count with pend[i]=1: hp[i] <= shadow[i], pend[i] <= 0. New value governs the next half-period; no runt pulse.
  - Disabled channel with pend[i]=1: applied on the next cycle, cnt[i]<=0, clk_out level kept.
- Simultaneous accept and terminal count on the same channel: not possible, since wr_ready=0 while pending. Accept in the same cycle as a terminal count with no prior pend: shadow loads and is applied at the following terminal count, not the current one.
- hp=1: clk_out toggles every cycle (25 MHz); tick high every other cycle.
- Counter width: cnt compared with hp-1 at CNT_W bits, no overflow possible.
- Reset mid-operation: immediate return to reset state; pending writes discarded.

Optional Feature:
PHASE_SYNC_EN
- Defined: adds input port sync_in (1 bit). While sync_in=1, all channels are held: cnt=0, clk_out=0, tick=0, and any pending shadow is applied immediately with pend cleared. On release, all channels restart phase-aligned; the first toggle on ch i comes hp[i] cycles after release.
- Undefined: sync_in port absent; behaviour as above.

Test Plan:
- Reset release with NUM_CH=2, DIV_INIT small (ch0=3, ch1=5), ch_en=11 -> clk_out[0] period 6 cycles, clk_out[1] period 10 cycles; tick[0] every 6 cycles aligned with the rising edge; all outputs 0 during rst.
- Write ch0 wr_div=2 mid-half-period -> pend[0]=1 and wr_ready low for ch0 until terminal count; after the current half-period completes, period becomes 4 cycles with no short pulse.
- wr_div=0 to ch1 -> treated as 1: clk_out[1] toggles every cycle and tick[1] is high on every other cycle.
- wr_ch=5 with NUM_CH=2 -> accepted (wr_ready=1), wr_err one-cycle pulse, no channel divisor changes.
- ch_en[0] dropped for 7 cycles at cnt=1 then re-asserted -> clk_out[0] frozen, tick[0]=0, count resumes from 1; rst asserted mid-period -> immediate return to reset values.
- PHASE_SYNC_EN: sync_in high 3 cycles with channels at arbitrary phase -> all clk_out=0 and cnt=0; after release, ch0 (hp=3) and ch1 (hp=5) first rise at cycles 3 and 5.
